// File: rtl/knn_stream_classifier_if.sv
// Training-sample stream: one labelled point per in_valid & in_ready beat.
// Latency: none (wires only).
// Backpressure: the sink drives in_ready; the source holds its payload until accepted.
interface knn_stream_classifier_if #(
    parameter int COORD_W = 16,
    parameter int DIMS    = 2,
    parameter int LABEL_W = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIMS*COORD_W-1:0]   in_pt;
    logic [LABEL_W-1:0]        in_label;
    logic                      in_last;

    modport master (
        output in_valid, in_pt, in_label, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pt, in_label, in_last,
        output in_ready
    );
endinterface

// File: rtl/knn_stream_classifier.sv
// k-NN classifier: streams labelled points, keeps the K nearest sorted, majority-votes the class.
// Latency: sample visible in nbr_* 2 cycles after accept; done 3+K+N_LABELS cycles after the last accept.
// Backpressure: in_ready is high only in STREAM; a gap on in_valid simply stalls the stream.
module knn_stream_classifier #(
    parameter  int COORD_W  = 16,
    parameter  int DIMS     = 2,
    parameter  int K        = 10,
    parameter  int LABEL_W  = 4,
    parameter  int N_LABELS = 10,
    localparam int DIST_W   = 2*COORD_W + 2 + $clog2(DIMS),
    localparam int CW       = $clog2(K+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIMS*COORD_W-1:0]  test_pt,
    knn_stream_classifier_if.slave   in_if,
    output logic                     busy,
    output logic                     done,
    output logic [LABEL_W-1:0]       class_out,
    output logic [CW-1:0]            nbr_count,
    output logic [K*DIST_W-1:0]      nbr_dists,
    output logic [K*LABEL_W-1:0]     nbr_labels
);
    localparam int SQ_W = 2*COORD_W + 2;

    typedef enum logic [2:0] {
        IDLE, STREAM, DRAIN, VOTE, ARGMAX, DONE
    } state_t;

    state_t                   state;
    logic                     in_ready_q;
    logic [DIMS*COORD_W-1:0]  test_q;
    logic                     drain_cnt;
    logic [CW-1:0]            vi;
    logic [LABEL_W-1:0]       ai;
    logic [LABEL_W-1:0]       best;
    logic [CW-1:0]            best_cnt;
    logic [CW-1:0]            cnt [N_LABELS];

    logic [DIST_W-1:0]        nbr_dist [K];
    logic [LABEL_W-1:0]       nbr_lab  [K];
    logic                     nbr_vld  [K];

    logic                     s1_vld;
    logic [SQ_W-1:0]          s1_sq [DIMS];
    logic [LABEL_W-1:0]       s1_label;

    logic [SQ_W-1:0]          sq_next [DIMS];
    logic [DIST_W-1:0]        new_dist;
    logic [CW-1:0]            ins_pos;
    logic [DIST_W-1:0]        ins_dist [K];
    logic [LABEL_W-1:0]       ins_lab  [K];
    logic                     ins_vld  [K];
    logic                     vote_vld;
    logic [LABEL_W-1:0]       vote_lab;
    logic [CW-1:0]            arg_cnt;
    logic                     accept;

    assign in_if.in_ready = in_ready_q;
    assign accept         = in_if.in_valid & in_ready_q;

    // Sign-extend both operands first so the difference and its square never wrap.
    function automatic logic [SQ_W-1:0] sq_diff(input logic [COORD_W-1:0] p,
                                                input logic [COORD_W-1:0] t);
        logic signed [SQ_W-1:0] pe, te, df;
        pe = SQ_W'($signed(p));
        te = SQ_W'($signed(t));
        df = pe - te;
        return df * df;
    endfunction

    always_comb begin
        for (int d = 0; d < DIMS; d++) begin
            sq_next[d] = sq_diff(in_if.in_pt[d*COORD_W +: COORD_W], test_q[d*COORD_W +: COORD_W]);
        end
    end

    // Stable insertion: a new point lands after every valid entry with an equal or smaller distance.
    always_comb begin
        new_dist = '0;
        for (int d = 0; d < DIMS; d++) begin
            new_dist = new_dist + DIST_W'(s1_sq[d]);
        end
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if (nbr_vld[i] && (nbr_dist[i] <= new_dist)) begin
                ins_pos = ins_pos + CW'(1);
            end
        end
        for (int i = 0; i < K; i++) begin
            ins_dist[i] = nbr_dist[i];
            ins_lab[i]  = nbr_lab[i];
            ins_vld[i]  = nbr_vld[i];
        end
        for (int i = 1; i < K; i++) begin
            if (CW'(i) > ins_pos) begin
                ins_dist[i] = nbr_dist[i-1];
                ins_lab[i]  = nbr_lab[i-1];
                ins_vld[i]  = nbr_vld[i-1];
            end
        end
        for (int i = 0; i < K; i++) begin
            if (CW'(i) == ins_pos) begin
                ins_dist[i] = new_dist;
                ins_lab[i]  = s1_label;
                ins_vld[i]  = 1'b1;
            end
        end
    end

    always_comb begin
        vote_vld = 1'b0;
        vote_lab = '0;
        for (int i = 0; i < K; i++) begin
            if (vi == CW'(i)) begin
                vote_vld = nbr_vld[i];
                vote_lab = nbr_lab[i];
            end
        end
        arg_cnt = '0;
        for (int j = 0; j < N_LABELS; j++) begin
            if (ai == LABEL_W'(j)) begin
                arg_cnt = cnt[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_out  <= '0;
            nbr_count  <= '0;
            test_q     <= '0;
            drain_cnt  <= 1'b0;
            vi         <= '0;
            ai         <= '0;
            best       <= '0;
            best_cnt   <= '0;
            s1_vld     <= 1'b0;
            s1_label   <= '0;
            for (int d = 0; d < DIMS; d++) s1_sq[d] <= '0;
            for (int j = 0; j < N_LABELS; j++) cnt[j] <= '0;
            for (int i = 0; i < K; i++) begin
                nbr_dist[i] <= '0;
                nbr_lab[i]  <= '0;
                nbr_vld[i]  <= 1'b0;
            end
        end else begin
            done   <= 1'b0;
            s1_vld <= accept;
            if (accept) begin
                s1_sq    <= sq_next;
                s1_label <= in_if.in_label;
            end
            if (s1_vld && (ins_pos != CW'(K))) begin
                nbr_dist <= ins_dist;
                nbr_lab  <= ins_lab;
                nbr_vld  <= ins_vld;
                if (nbr_count != CW'(K)) nbr_count <= nbr_count + CW'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= STREAM;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        test_q     <= test_pt;
                        nbr_count  <= '0;
                        for (int j = 0; j < N_LABELS; j++) cnt[j] <= '0;
                        for (int i = 0; i < K; i++) begin
                            nbr_dist[i] <= '0;
                            nbr_lab[i]  <= '0;
                            nbr_vld[i]  <= 1'b0;
                        end
                    end
                end
                STREAM: begin
                    if (accept && in_if.in_last) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                        drain_cnt  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= VOTE;
                        vi    <= '0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                VOTE: begin
                    // Out-of-range labels match no counter and so cast no vote.
                    for (int j = 0; j < N_LABELS; j++) begin
                        if (vote_vld && (vote_lab == LABEL_W'(j))) cnt[j] <= cnt[j] + CW'(1);
                    end
                    if (vi == CW'(K-1)) begin
                        state    <= ARGMAX;
                        ai       <= '0;
                        best     <= '0;
                        best_cnt <= '0;
                    end else begin
                        vi <= vi + CW'(1);
                    end
                end
                ARGMAX: begin
                    if (arg_cnt > best_cnt) begin
                        best     <= ai;
                        best_cnt <= arg_cnt;
                    end
                    if (ai == LABEL_W'(N_LABELS-1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        class_out <= (arg_cnt > best_cnt) ? ai : best;
                    end else begin
                        ai <= ai + LABEL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign nbr_dists[g*DIST_W +: DIST_W]   = nbr_dist[g];
        assign nbr_labels[g*LABEL_W +: LABEL_W] = nbr_lab[g];
    end
endmodule

// File: tb/tb_knn_stream_classifier.sv
// Directed bench for knn_stream_classifier with K=3, DIMS=2, COORD_W=8, LABEL_W=2, N_LABELS=4.
module tb_knn_stream_classifier;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] test_pt = '0;
    logic        busy, done;
    logic [1:0]  class_out, nbr_count;
    logic [56:0] nbr_dists;
    logic [5:0]  nbr_labels;
    int          checks = 0;
    int          errors = 0;

    knn_stream_classifier_if #(.COORD_W(8), .DIMS(2), .LABEL_W(2)) bus ();

    knn_stream_classifier #(.COORD_W(8), .DIMS(2), .K(3), .LABEL_W(2), .N_LABELS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .test_pt(test_pt), .in_if(bus),
        .busy(busy), .done(done), .class_out(class_out), .nbr_count(nbr_count),
        .nbr_dists(nbr_dists), .nbr_labels(nbr_labels)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int x, input int y);
        start   = 1'b1;
        test_pt = {8'(y), 8'(x)};
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int lab, input bit last, input int gap);
        bit ok;
        int n;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_pt    = {8'(y), 8'(x)};
        bus.in_label = 2'(lab);
        bus.in_last  = last;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            ok = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL handshake: in_ready never seen for (%0d,%0d), got %0b expected 1", x, y, ok);
        end
    endtask

    // Called right after the last handshake edge; lat counts the handshake cycle as cycle 0.
    task automatic wait_done(output int lat, output bit rdy_seen);
        lat      = 1;
        rdy_seen = bus.in_ready;
        while (!done && lat < 60) begin
            tick();
            lat++;
            if (!done && bus.in_ready) rdy_seen = 1'b1;
        end
    endtask

    task automatic run_scen1(input int gap, output int lat, output bit rdy_seen);
        do_start(0, 0);
        send(1, 0, 1, 1'b0, gap);
        send(5, 5, 2, 1'b0, gap);
        send(0, 2, 1, 1'b0, gap);
        send(3, 0, 3, 1'b1, gap);
        wait_done(lat, rdy_seen);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.in_ready, busy, done});
        end
        checks++;
        if ({class_out, nbr_count} !== 4'b0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 0", {class_out, nbr_count});
        end
        checks++;
        if ({nbr_dists, nbr_labels} !== '0) begin
            errors++;
            $display("FAIL reset_list: got %h expected 0", {nbr_dists, nbr_labels});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bit rs;
        run_scen1(0, lat, rs);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 10", lat);
        end
        checks++;
        if (nbr_dists !== {19'd9, 19'd4, 19'd1}) begin
            errors++;
            $display("FAIL basic_dists: got %h expected %h", nbr_dists, {19'd9, 19'd4, 19'd1});
        end
        checks++;
        if (nbr_labels !== {2'd3, 2'd1, 2'd1} || nbr_count !== 2'd3) begin
            errors++;
            $display("FAIL basic_labels: got %h/%0d expected 35/3", nbr_labels, nbr_count);
        end
        checks++;
        if (class_out !== 2'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_class: got %0d busy %0b expected 1 busy 0", class_out, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || class_out !== 2'd1) begin
            errors++;
            $display("FAIL basic_done_pulse: got done %0b class %0d expected 0 and 1", done, class_out);
        end
    endtask

    task automatic test_underfill();
        int lat;
        bit rs;
        do_start(0, 0);
        send(2, 0, 2, 1'b0, 0);
        send(1, 1, 3, 1'b1, 0);
        wait_done(lat, rs);
        checks++;
        if (nbr_count !== 2'd2 || nbr_dists[37:0] !== {19'd4, 19'd2}) begin
            errors++;
            $display("FAIL underfill_dists: got %0d %h expected 2 %h", nbr_count, nbr_dists[37:0], {19'd4, 19'd2});
        end
        checks++;
        if (nbr_labels[3:0] !== {2'd2, 2'd3} || class_out !== 2'd2) begin
            errors++;
            $display("FAIL underfill_vote: got labels %h class %0d expected b class 2", nbr_labels[3:0], class_out);
        end
    endtask

    task automatic test_equal_dist();
        int lat;
        bit rs;
        do_start(0, 0);
        send(1, 0, 2, 1'b0, 0);
        send(0, 1, 0, 1'b0, 0);
        send(0, -1, 1, 1'b1, 0);
        wait_done(lat, rs);
        checks++;
        if (nbr_labels !== {2'd1, 2'd0, 2'd2} || nbr_dists !== {19'd1, 19'd1, 19'd1}) begin
            errors++;
            $display("FAIL equal_order: got %h %h expected 12 and all-ones distances", nbr_labels, nbr_dists);
        end
        checks++;
        if (class_out !== 2'd0) begin
            errors++;
            $display("FAIL equal_vote: got %0d expected 0", class_out);
        end
    endtask

    task automatic test_extremes();
        int lat;
        bit rs;
        do_start(-128, -128);
        send(127, 127, 3, 1'b1, 0);
        wait_done(lat, rs);
        checks++;
        if (nbr_dists[18:0] !== 19'd130050 || nbr_count !== 2'd1) begin
            errors++;
            $display("FAIL extremes_dist: got %0d count %0d expected 130050 count 1", nbr_dists[18:0], nbr_count);
        end
        checks++;
        if (class_out !== 2'd3) begin
            errors++;
            $display("FAIL extremes_class: got %0d expected 3", class_out);
        end
    endtask

    task automatic test_handshake();
        int lat;
        bit rs;
        do_start(0, 0);
        send(1, 0, 1, 1'b0, 2);
        send(5, 5, 2, 1'b0, 0);
        start   = 1'b1;
        test_pt = {8'd100, 8'd100};
        tick();
        start   = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midstart_busy: got busy %0b ready %0b expected 1 1", busy, bus.in_ready);
        end
        send(0, 2, 1, 1'b0, 3);
        send(3, 0, 3, 1'b1, 1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop: got %0b expected 0", bus.in_ready);
        end
        wait_done(lat, rs);
        checks++;
        if (rs !== 1'b0 || lat !== 10) begin
            errors++;
            $display("FAIL ready_low_drain: got ready_seen %0b lat %0d expected 0 10", rs, lat);
        end
        checks++;
        if (nbr_dists !== {19'd9, 19'd4, 19'd1} || nbr_labels !== {2'd3, 2'd1, 2'd1} || class_out !== 2'd1) begin
            errors++;
            $display("FAIL gaps_result: got %h %h %0d expected scenario 1 results", nbr_dists, nbr_labels, class_out);
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        bit rs;
        bit done_seen;
        do_start(0, 0);
        send(1, 0, 1, 1'b0, 0);
        send(5, 5, 2, 1'b0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({bus.in_ready, busy, nbr_count} !== 4'b0) begin
            errors++;
            $display("FAIL midreset_state: got %b expected 0000", {bus.in_ready, busy, nbr_count});
        end
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0 || nbr_count !== 2'd0) begin
            errors++;
            $display("FAIL midreset_quiet: got done_seen %0b count %0d expected 0 0", done_seen, nbr_count);
        end
        run_scen1(0, lat, rs);
        checks++;
        if (lat !== 10 || nbr_dists !== {19'd9, 19'd4, 19'd1} || nbr_labels !== {2'd3, 2'd1, 2'd1} || class_out !== 2'd1) begin
            errors++;
            $display("FAIL midreset_rerun: got lat %0d %h %h %0d expected scenario 1 results", lat, nbr_dists, nbr_labels, class_out);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pt    = '0;
        bus.in_label = '0;
        bus.in_last  = 1'b0;
        test_reset();
        test_basic();
        test_underfill();
        test_equal_dist();
        test_extremes();
        test_handshake();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
